// File: rtl/data_memory_param.sv
// ============================================================================
// Module      : data_memory_param
// Description : Byte-addressed data memory with fixed busywait latency and RV32 load/store sizing.
//               Optional misalignment fault when DMEM_MISALIGN_FAULT_EN is defined.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module data_memory_param #(
    parameter int DEPTH_BYTES = 4096,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic [2:0]  write_ctrl,
    input  logic [3:0]  read_ctrl,
    output logic [31:0] read_data,
    output logic        busywait,
    output logic        fault
);

    localparam int AW = $clog2(DEPTH_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [3:0]     cnt_q;
    logic [AW-1:0]  addr_q;
    logic [31:0]    wdata_q;
    logic [2:0]     wctrl_q;
    logic [3:0]     rctrl_q;
    logic [31:0]    read_data_q;
    logic [7:0]     mem [DEPTH_BYTES];

    logic           w_req;
    logic           w_exec;
    logic           w_wr;
    logic           w_rd;
    logic [1:0]     w_size;
    logic [3:0]     w_lane;
    logic           w_misal;
    logic [AW-1:0]  w_ba [4];
    logic [7:0]     w_rb [4];
    logic [31:0]    w_load;
    logic           w_unused_addr;

    assign w_unused_addr = ^addr[31:AW];
    assign w_req    = read_ctrl[3] | write_ctrl[2];
    assign busywait = ((state_q == IDLE) && w_req) || (state_q == BUSY);
    // The request cycle already counts toward LATENCY, so BUSY ends one count early.
    assign w_exec   = (state_q == BUSY) && (cnt_q <= 4'd1);
    assign w_wr     = wctrl_q[2];
    assign w_rd     = rctrl_q[3] & ~wctrl_q[2];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_ba[i] = addr_q + AW'(i);
            w_rb[i] = mem[w_ba[i]];
        end
    end

    always_comb begin
        w_size = 2'b00;
        if (w_wr) begin
            w_size = wctrl_q[1:0];
        end else if (rctrl_q[2:0] == 3'b010) begin
            w_size = 2'b10;
        end else if (rctrl_q[1:0] == 2'b01) begin
            w_size = 2'b01;
        end
    end

    always_comb begin
        w_lane = 4'b0000;
        case (wctrl_q[1:0])
            2'b00:   w_lane = 4'b0001;
            2'b01:   w_lane = 4'b0011;
            2'b10:   w_lane = 4'b1111;
            default: w_lane = 4'b0000;
        endcase
    end

    always_comb begin
        w_load = 32'd0;
        case (rctrl_q[2:0])
            3'b000:  w_load = {{24{w_rb[0][7]}}, w_rb[0]};
            3'b001:  w_load = {{16{w_rb[1][7]}}, w_rb[1], w_rb[0]};
            3'b010:  w_load = {w_rb[3], w_rb[2], w_rb[1], w_rb[0]};
            3'b100:  w_load = {24'd0, w_rb[0]};
            3'b101:  w_load = {16'd0, w_rb[1], w_rb[0]};
            default: w_load = 32'd0;
        endcase
    end

`ifdef DMEM_MISALIGN_FAULT_EN
    logic fault_q;

    assign w_misal = ((w_size == 2'b01) && addr_q[0]) ||
                     ((w_size == 2'b10) && (addr_q[1:0] != 2'b00));
    assign fault   = fault_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= w_exec && w_misal;
        end
    end
`else
    logic w_unused_size;

    assign w_unused_size = ^w_size;
    assign w_misal       = 1'b0;
    assign fault         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            wctrl_q     <= 3'd0;
            rctrl_q     <= 4'd0;
            read_data_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_req) begin
                        addr_q  <= addr[AW-1:0];
                        wdata_q <= write_data;
                        wctrl_q <= write_ctrl;
                        rctrl_q <= read_ctrl;
                        cnt_q   <= 4'(LATENCY - 1);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_exec) begin
                        cnt_q   <= 4'd0;
                        state_q <= DONE;
                        if (w_rd) begin
                            read_data_q <= w_misal ? 32'd0 : w_load;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Storage is deliberately left out of reset; reset only gates the pending write.
    always_ff @(posedge clk) begin
        if (!reset && w_exec && w_wr && !w_misal) begin
            for (int i = 0; i < 4; i++) begin
                if (w_lane[i]) begin
                    mem[w_ba[i]] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign read_data = read_data_q;

endmodule

`default_nettype wire

// File: tb/tb_data_memory_param.sv
// ============================================================================
// Module      : tb_data_memory_param
// Description : Directed vector bench for data_memory_param (DEPTH_BYTES=64, LATENCY=2).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_data_memory_param;

    localparam logic [2:0] SB = 3'b100, SH = 3'b101, SW = 3'b110, SX = 3'b111, NW = 3'b000;
    localparam logic [3:0] LB = 4'b1000, LH = 4'b1001, LW = 4'b1010;
    localparam logic [3:0] LBU = 4'b1100, LHU = 4'b1101, LX = 4'b1011, NR = 4'b0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [2:0]  write_ctrl;
    logic [3:0]  read_ctrl;
    logic [31:0] read_data;
    logic        busywait;
    logic        fault;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] wd;
        logic [2:0]  wc;
        logic [3:0]  rc;
        logic [31:0] rd;
        logic        f;
    } vec_t;

    vec_t vq[$];

    data_memory_param #(.DEPTH_BYTES(64), .LATENCY(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .write_data (write_data),
        .write_ctrl (write_ctrl),
        .read_ctrl  (read_ctrl),
        .read_data  (read_data),
        .busywait   (busywait),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] wc,
                                input logic [3:0] rc, input logic [31:0] rd, input logic f);
        vec_t v;
        v.a = a; v.wd = wd; v.wc = wc; v.rc = rc; v.rd = rd; v.f = f;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the IDLE cycle after DONE.
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] wc,
                          input logic [3:0] rc, output int bw, output logic [31:0] rd,
                          output logic f);
        addr = a; write_data = wd; write_ctrl = wc; read_ctrl = rc;
        #1;
        bw = 0;
        while (busywait === 1'b1 && bw < 20) begin
            bw++;
            @(posedge clk); #1;
            addr = ~a; write_data = ~wd; write_ctrl = NW; read_ctrl = NR;
            #1;
        end
        rd = read_data;
        f  = fault;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          bw;
        logic [31:0] rd;
        logic        f;
        int          bw_exp[6];

        reset = 1'b1; addr = 32'd0; write_data = 32'd0; write_ctrl = NW; read_ctrl = NR;
        repeat (2) @(posedge clk);
        #1;
        chk("reset read_data", read_data, 32'd0);
        chk("reset busywait", {31'd0, busywait}, 32'd0);
        chk("reset fault", {31'd0, fault}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        add(32'h10, 32'hDEADBEEF, SW, NR, 32'h00000000, 1'b0);
        add(32'h10, 32'h0,        NW, LW, 32'hDEADBEEF, 1'b0);
        add(32'h21, 32'h80,       SB, NR, 32'hDEADBEEF, 1'b0);
        add(32'h20, 32'h0,        SB, NR, 32'hDEADBEEF, 1'b0);
        add(32'h21, 32'h0,        NW, LB, 32'hFFFFFF80, 1'b0);
        add(32'h21, 32'h0,        NW, LBU, 32'h00000080, 1'b0);
        add(32'h20, 32'h0,        NW, LH, 32'hFFFF8000, 1'b0);
        add(32'h20, 32'h0,        NW, LHU, 32'h00008000, 1'b0);
        add(32'h10, 32'h0,        NW, LB, 32'hFFFFFFEF, 1'b0);
        add(32'h12, 32'h0,        NW, LH, 32'hFFFFDEAD, 1'b0);
        add(32'h10, 32'h0,        NW, LX, 32'h00000000, 1'b0);
        add(32'h08, 32'h12345678, SW, NR, 32'h00000000, 1'b0);
        add(32'h08, 32'h0000BEEF, SH, LW, 32'h00000000, 1'b0);
        add(32'h08, 32'h0,        NW, LW, 32'h1234BEEF, 1'b0);
        add(32'h08, 32'hFFFFFFFF, SX, NR, 32'h1234BEEF, 1'b0);
        add(32'h08, 32'h0,        NW, LW, 32'h1234BEEF, 1'b0);
`ifndef DMEM_MISALIGN_FAULT_EN
        add(32'h3E, 32'h11223344, SW, NR, 32'h1234BEEF, 1'b0);
        add(32'h3E, 32'h0,        NW, LW, 32'h11223344, 1'b0);
        add(32'h3F, 32'h0,        NW, LBU, 32'h00000033, 1'b0);
        add(32'h00, 32'h0,        NW, LBU, 32'h00000022, 1'b0);
        add(32'h01, 32'h0,        NW, LBU, 32'h00000011, 1'b0);
        add(32'h3E, 32'h0,        NW, LBU, 32'h00000044, 1'b0);
        add(32'h7E, 32'h0,        NW, LW, 32'h11223344, 1'b0);
`else
        add(32'h00, 32'hAABBCCDD, SW, NR, 32'h1234BEEF, 1'b0);
        add(32'h00, 32'h0,        NW, LW, 32'hAABBCCDD, 1'b0);
        add(32'h13, 32'h0,        NW, LW, 32'h00000000, 1'b1);
        add(32'h02, 32'h55667788, SW, NR, 32'h00000000, 1'b1);
        add(32'h00, 32'h0,        NW, LW, 32'hAABBCCDD, 1'b0);
        add(32'h01, 32'h0,        NW, LH, 32'h00000000, 1'b1);
`endif

        foreach (vq[i]) begin
            access(vq[i].a, vq[i].wd, vq[i].wc, vq[i].rc, bw, rd, f);
            chk($sformatf("vec%0d busywait_cycles", i), 32'(bw), 32'd2);
            chk($sformatf("vec%0d read_data", i), rd, vq[i].rd);
            chk($sformatf("vec%0d fault", i), {31'd0, f}, {31'd0, vq[i].f});
        end

        // Request held across DONE starts a second access immediately.
        bw_exp = '{1, 1, 0, 1, 1, 0};
        addr = 32'h10; write_data = 32'h0; write_ctrl = NW; read_ctrl = LW;
        #1;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("b2b busywait k%0d", k), {31'd0, busywait}, 32'(bw_exp[k]));
            if (k == 2) chk("b2b read_data", read_data, 32'hDEADBEEF);
            if (k < 5) begin
                @(posedge clk); #1;
            end
        end
        read_ctrl = NR;
        @(posedge clk); #1;

        // Reset in the first BUSY cycle cancels the store.
        access(32'h40, 32'h0, SW, NR, bw, rd, f);
        addr = 32'h40; write_data = 32'hA5A5A5A5; write_ctrl = SW; read_ctrl = NR;
        #1;
        @(posedge clk); #1;
        write_ctrl = NW;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("cancel read_data", read_data, 32'd0);
        chk("cancel busywait", {31'd0, busywait}, 32'd0);
        chk("cancel fault", {31'd0, fault}, 32'd0);
        @(posedge clk); #1;
        access(32'h40, 32'h0, NW, LW, bw, rd, f);
        chk("cancel busywait_cycles", 32'(bw), 32'd2);
        chk("cancel mem", rd, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
